// File: rtl/qoi_types.sv
// Shared QOI codec types: default widths, buffer ownership states
// and the transfer-length type used by the handshaked buffer pair.
package qoi_types;

  localparam int BYTE_W = 8;
  localparam int ADDR_DEF_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [ADDR_DEF_W-1:0] addr_t;
  typedef logic [ADDR_DEF_W:0] xfer_len_t;

  typedef enum logic [1:0] {
    HOST_FILL = 2'd0,
    ENGINE    = 2'd1,
    RESULT    = 2'd2
  } buf_state_t;

endpackage

// File: rtl/qoi_bank_ram.sv
// Single-port synchronous bank RAM; dout updates only on an accepted
// read and otherwise holds, so it doubles as the port's read register.
module qoi_bank_ram
  import qoi_types::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (cs && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (cs && !we) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/qoi_xfer_buffer.sv
// Handshaked input/output bank pair between the host bus adapter
// (port A) and the QOI engine (port B), with FSM-owned banks.
module qoi_xfer_buffer
  import qoi_types::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter bit AUTO_COMMIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              a_cs,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_cs,
  input  logic              b_we,
  input  logic              host_commit,
  input  logic [ADDR_W:0]   commit_len,
  input  logic              engine_done,
  input  logic              host_ack,
  output logic              b_start,
  output logic [ADDR_W:0]   in_len,
  output logic [ADDR_W:0]   out_len,
  output logic              irq,
  output logic              last_o,
  output logic              err
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  buf_state_t state;

  logic host_own;
  logic a_wr, a_rd, b_wr, b_rd;
  logic a_last, go_cmd, go_auto;
  logic zero_cmd, viol;
  logic [ADDR_W:0] sat_len, b_end;

  assign host_own = (state == HOST_FILL) || (state == RESULT);

  assign a_wr = host_own && a_cs && a_we;
  assign a_rd = host_own && a_cs && !a_we;
  assign b_wr = (state == ENGINE) && b_cs && b_we;
  assign b_rd = (state == ENGINE) && b_cs && !b_we;

  assign a_last = a_wr && (a_addr == '1);

  assign zero_cmd = (state == HOST_FILL) && host_commit
                 && (commit_len == '0);
  assign go_cmd = (state == HOST_FILL) && host_commit
               && (commit_len != '0);
  assign go_auto = AUTO_COMMIT && (state == HOST_FILL) && a_last;

  assign sat_len = (commit_len > FULL) ? FULL : commit_len;
  assign b_end = {1'b0, b_addr} + 1'b1;

  // Reads past the committed length still return data but are flagged.
  assign viol = zero_cmd
             || ((state != ENGINE) && b_cs)
             || ((state == ENGINE) && a_cs)
             || (b_rd && ({1'b0, b_addr} >= in_len));

  assign irq = (state == RESULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOST_FILL;
      in_len  <= '0;
      out_len <= '0;
      b_start <= 1'b0;
      last_o  <= 1'b0;
      err     <= 1'b0;
    end else begin
      b_start <= 1'b0;
      last_o  <= a_last;
      if (viol) err <= 1'b1;
      unique case (state)
        HOST_FILL: begin
          if (go_cmd || go_auto) begin
            state   <= ENGINE;
            b_start <= 1'b1;
            out_len <= '0;
            in_len  <= go_cmd ? sat_len : FULL;
          end
        end
        ENGINE: begin
          if (b_wr && (b_end > out_len)) out_len <= b_end;
          if (engine_done) state <= RESULT;
        end
        RESULT: begin
          if (host_ack) state <= HOST_FILL;
        end
        default: state <= HOST_FILL;
      endcase
    end
  end

  // Input bank: host writes, engine reads.
  qoi_bank_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_in_bank (
    .clk  (clk),
    .rst  (rst),
    .cs   (a_wr || b_rd),
    .we   (a_wr),
    .addr (a_wr ? a_addr : b_addr),
    .wdata(a_wdata),
    .dout (b_rdata)
  );

  // Output bank: engine writes, host reads.
  qoi_bank_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_out_bank (
    .clk  (clk),
    .rst  (rst),
    .cs   (b_wr || a_rd),
    .we   (b_wr),
    .addr (b_wr ? b_addr : a_addr),
    .wdata(b_wdata),
    .dout (a_rdata)
  );

endmodule
